// File: rtl/minibyte2_cpu.sv
// MiniByte2 accumulator core: A/PC/M/IR registers, Z/N flags and a request/ready memory FSM.
// Define MINIBYTE2_CARRY_EN to add the carry flag, ADC (opcode D) and JC (opcode E).
module minibyte2_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_ready_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic              req_out,
    output logic              halt_out
);

    localparam logic [3:0] OP_NOT = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JN  = 4'hB;
`ifdef MINIBYTE2_CARRY_EN
    localparam logic [3:0] OP_ADC = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
`endif

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, MEM, HALT} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] m_reg, m_next;
    logic [3:0]        ir_reg, ir_next;
    logic              z_reg, z_next;
    logic              n_reg, n_next;
    logic              a_wr;

    logic [3:0]        op_w;
    logic [ADDR_W-1:0] arg_w;
    logic [ADDR_W-1:0] pc_inc_w;
    logic              operand_op_w;
    logic [DATA_W-1:0] and_w, or_w, xor_w;

    assign op_w     = data_in[3:0];
    assign arg_w    = data_in[ADDR_W-1:0];
    assign pc_inc_w = pc_reg + PC_ONE;

`ifdef MINIBYTE2_CARRY_EN
    logic              c_reg, c_next;
    logic              cin_w;
    logic [DATA_W:0]   sum_w, diff_w;
    assign cin_w        = (ir_reg == OP_ADC) & c_reg;
    assign sum_w        = {1'b0, a_reg} + {1'b0, data_in} + {{DATA_W{1'b0}}, cin_w};
    assign diff_w       = {1'b0, a_reg} - {1'b0, data_in};
    assign operand_op_w = ((op_w >= OP_LDI) && (op_w <= OP_JN)) || (op_w == OP_ADC) || (op_w == OP_JC);
`else
    logic [DATA_W-1:0] sum_w, diff_w;
    assign sum_w        = a_reg + data_in;
    assign diff_w       = a_reg - data_in;
    assign operand_op_w = (op_w >= OP_LDI) && (op_w <= OP_JN);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_logic_unit
            assign and_w[gi] = a_reg[gi] & data_in[gi];
            assign or_w[gi]  = a_reg[gi] | data_in[gi];
            assign xor_w[gi] = a_reg[gi] ^ data_in[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        pc_next    = pc_reg;
        m_next     = m_reg;
        ir_next    = ir_reg;
        z_next     = z_reg;
        n_next     = n_reg;
        a_wr       = 1'b0;
`ifdef MINIBYTE2_CARRY_EN
        c_next     = c_reg;
`endif
        case (state_reg)
            FETCH_OP: begin
                if (mem_ready_in) begin
                    pc_next = pc_inc_w;
                    ir_next = op_w;
                    if (op_w == OP_NOT) begin
                        a_next = ~a_reg;
                        a_wr   = 1'b1;
                    end else if (op_w == OP_HLT) begin
                        state_next = HALT;
                    end else if (operand_op_w) begin
                        state_next = FETCH_ARG;
                    end
                end
            end
            FETCH_ARG: begin
                if (mem_ready_in) begin
                    m_next     = arg_w;
                    pc_next    = pc_inc_w;
                    state_next = FETCH_OP;
                    // Jumps replace the increment; memory-operand ops continue to MEM.
                    case (ir_reg)
                        OP_LDI: begin
                            a_next = data_in;
                            a_wr   = 1'b1;
                        end
                        OP_JMP: pc_next = arg_w;
                        OP_JZ:  if (z_reg) pc_next = arg_w;
                        OP_JN:  if (n_reg) pc_next = arg_w;
`ifdef MINIBYTE2_CARRY_EN
                        OP_JC:  if (c_reg) pc_next = arg_w;
`endif
                        default: state_next = MEM;
                    endcase
                end
            end
            MEM: begin
                if (mem_ready_in) begin
                    state_next = FETCH_OP;
                    case (ir_reg)
                        OP_LDA: begin
                            a_next = data_in;
                            a_wr   = 1'b1;
                        end
                        OP_ADD: begin
                            a_next = sum_w[DATA_W-1:0];
                            a_wr   = 1'b1;
`ifdef MINIBYTE2_CARRY_EN
                            c_next = sum_w[DATA_W];
`endif
                        end
                        OP_SUB: begin
                            a_next = diff_w[DATA_W-1:0];
                            a_wr   = 1'b1;
`ifdef MINIBYTE2_CARRY_EN
                            c_next = ~diff_w[DATA_W];
`endif
                        end
`ifdef MINIBYTE2_CARRY_EN
                        OP_ADC: begin
                            a_next = sum_w[DATA_W-1:0];
                            a_wr   = 1'b1;
                        end
`endif
                        OP_AND: begin
                            a_next = and_w;
                            a_wr   = 1'b1;
                        end
                        OP_OR: begin
                            a_next = or_w;
                            a_wr   = 1'b1;
                        end
                        OP_XOR: begin
                            a_next = xor_w;
                            a_wr   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH_OP;
        endcase
        if (a_wr) begin
            z_next = (a_next == '0);
            n_next = a_next[DATA_W-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= FETCH_OP;
            a_reg     <= '0;
            pc_reg    <= '0;
            m_reg     <= '0;
            ir_reg    <= '0;
            z_reg     <= 1'b1;
            n_reg     <= 1'b0;
`ifdef MINIBYTE2_CARRY_EN
            c_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            pc_reg    <= pc_next;
            m_reg     <= m_next;
            ir_reg    <= ir_next;
            z_reg     <= z_next;
            n_reg     <= n_next;
`ifdef MINIBYTE2_CARRY_EN
            c_reg     <= c_next;
`endif
        end
    end

    // Requests are suppressed during reset so an in-flight access is dropped cleanly.
    assign req_out  = !rst_in && (state_reg != HALT);
    assign addr_out = (state_reg == MEM) ? m_reg : pc_reg;
    assign we_out   = req_out && (state_reg == MEM) && (ir_reg == OP_STA);
    assign data_out = a_reg;
    assign halt_out = (state_reg == HALT);

endmodule
